// File: rtl/seg_scan_driver_2digit_if.sv
// seg_scan_driver_2digit_if
// Bundles the counter-side inputs and display-side outputs of the two-digit
// seven-segment scan driver.
//   Qin1/Qin2  : counter low/high nibble
//   Carry_in   : ripple carries, [0] low stage, [1] high stage
//   Ovf_Clr    : synchronous clear of the sticky overflow flag
//   Seg        : {g,f,e,d,c,b,a}, active-low
//   Dp         : decimal point, active-low
//   Digit_N    : digit enables, active-low, [0] low digit, [1] high digit
//   Ovf        : sticky overflow flag
// master = stimulus/counter side, slave = driver side.
interface seg_scan_driver_2digit_if;
    logic [3:0] Qin1;
    logic [3:0] Qin2;
    logic [1:0] Carry_in;
    logic       Ovf_Clr;
    logic [6:0] Seg;
    logic       Dp;
    logic [1:0] Digit_N;
    logic       Ovf;

    modport master (
        output Qin1, Qin2, Carry_in, Ovf_Clr,
        input  Seg, Dp, Digit_N, Ovf
    );

    modport slave (
        input  Qin1, Qin2, Carry_in, Ovf_Clr,
        output Seg, Dp, Digit_N, Ovf
    );
endinterface

// File: rtl/seg_scan_driver_2digit.sv
// seg_scan_driver_2digit
// Two-digit multiplexed common-anode seven-segment driver fed by an 8-bit
// cascaded counter. The counter is snapshotted on entry to the low-digit slot
// so a whole frame shows one consistent value; each digit slot is followed by
// a one-cycle all-off gap so the two digit enables never overlap.
// Ports:
//   clk      : rising-edge clock
//   Reset_N  : asynchronous active-low reset
//   bus      : slave modport of seg_scan_driver_2digit_if (counter in, display out)
// Parameter:
//   SCAN_DIV : cycles per digit slot including the gap (2..65535)
// Optional feature:
//   LZ_BLANK_EN : when defined, the high digit is blanked if its snapshot is 0
//                 (decimal point still shows the overflow flag).
module seg_scan_driver_2digit #(
    parameter int unsigned SCAN_DIV = 4
) (
    input  logic                     clk,
    input  logic                     Reset_N,
    seg_scan_driver_2digit_if.slave  bus
);

    typedef enum logic [1:0] {
        S_D0 = 2'd0,
        S_G0 = 2'd1,
        S_D1 = 2'd2,
        S_G1 = 2'd3
    } state_t;

    localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 2);
    localparam logic [6:0]  SEG_OFF  = 7'h7F;

    state_t      state;
    logic [15:0] div;
    logic [3:0]  snap1;
    logic [3:0]  snap2;
    logic        snapc;
    logic        ovf_nxt;

    function automatic logic [6:0] dec(input logic [3:0] v);
        logic [6:0] s;
        s = SEG_OFF;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
            default: s = SEG_OFF;
        endcase
        return s;
    endfunction

    function automatic logic [6:0] hi_seg(input logic [3:0] v);
`ifdef LZ_BLANK_EN
        return (v == 4'h0) ? SEG_OFF : dec(v);
`else
        return dec(v);
`endif
    endfunction

    // Set wins over clear. The high-digit Dp is loaded from this same value so
    // it lines up with the Ovf register on every edge instead of lagging it.
    assign ovf_nxt = bus.Carry_in[1] | (bus.Ovf & ~bus.Ovf_Clr);

    always_ff @(posedge clk or negedge Reset_N) begin
        if (!Reset_N) begin
            bus.Ovf <= 1'b0;
        end else begin
            bus.Ovf <= ovf_nxt;
        end
    end

    always_ff @(posedge clk or negedge Reset_N) begin
        if (!Reset_N) begin
            state       <= S_G1;
            div         <= '0;
            snap1       <= '0;
            snap2       <= '0;
            snapc       <= 1'b0;
            bus.Seg     <= SEG_OFF;
            bus.Dp      <= 1'b1;
            bus.Digit_N <= 2'b11;
        end else begin
            case (state)
                S_D0: begin
                    if (div == DIV_LAST) begin
                        state       <= S_G0;
                        div         <= '0;
                        bus.Seg     <= SEG_OFF;
                        bus.Dp      <= 1'b1;
                        bus.Digit_N <= 2'b11;
                    end else begin
                        div <= div + 16'd1;
                    end
                end
                S_G0: begin
                    state       <= S_D1;
                    div         <= '0;
                    bus.Seg     <= hi_seg(snap2);
                    bus.Dp      <= ~ovf_nxt;
                    bus.Digit_N <= 2'b01;
                end
                S_D1: begin
                    // Overflow is live, so the high-digit Dp refreshes every cycle.
                    bus.Dp <= ~ovf_nxt;
                    if (div == DIV_LAST) begin
                        state       <= S_G1;
                        div         <= '0;
                        bus.Seg     <= SEG_OFF;
                        bus.Dp      <= 1'b1;
                        bus.Digit_N <= 2'b11;
                    end else begin
                        div <= div + 16'd1;
                    end
                end
                default: begin // S_G1: frame start, take the snapshot
                    state       <= S_D0;
                    div         <= '0;
                    snap1       <= bus.Qin1;
                    snap2       <= bus.Qin2;
                    snapc       <= bus.Carry_in[0];
                    // Outputs are built from the inputs being captured so the
                    // first low-digit cycle already shows the new snapshot.
                    bus.Seg     <= dec(bus.Qin1);
                    bus.Dp      <= ~bus.Carry_in[0];
                    bus.Digit_N <= 2'b10;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg_scan_driver_2digit.sv
module tb_seg_scan_driver_2digit;
    localparam int SD = 4;

    typedef struct packed {
        logic [6:0] seg;
        logic       dp;
        logic [1:0] dn;
        logic       ovf;
    } exp_t;

    logic clk = 1'b0;
    logic Reset_N;
    always #5 clk = ~clk;

    seg_scan_driver_2digit_if bus();

    seg_scan_driver_2digit #(.SCAN_DIV(SD)) dut (
        .clk     (clk),
        .Reset_N (Reset_N),
        .bus     (bus)
    );

    logic [6:0] dec_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: position within the frame since reset release.
    int         m_k   = 0;
    logic [3:0] m_s1  = '0;
    logic [3:0] m_s2  = '0;
    logic       m_sc  = 1'b0;
    logic       m_ovf = 1'b0;

    task automatic chk(input string nm, input logic [6:0] act, input logic [6:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Caller sits at a negedge; inputs are applied, the next rising edge is
    // modelled, and the call returns at the following negedge.
    task automatic cyc(input logic [3:0] q1, input logic [3:0] q2,
                       input logic [1:0] c, input logic clr);
        int   p;
        exp_t e;
        bus.Qin1     = q1;
        bus.Qin2     = q2;
        bus.Carry_in = c;
        bus.Ovf_Clr  = clr;
        @(posedge clk);
        p = m_k % (2 * SD);
        m_ovf = c[1] | (m_ovf & ~clr);
        if (p == 0) begin
            m_s1 = q1;
            m_s2 = q2;
            m_sc = c[0];
        end
        e.seg = 7'h7F;
        e.dp  = 1'b1;
        e.dn  = 2'b11;
        e.ovf = m_ovf;
        if (p < SD - 1) begin
            e.dn  = 2'b10;
            e.seg = dec_tab[m_s1];
            e.dp  = ~m_sc;
        end else if (p >= SD && p < 2 * SD - 1) begin
            e.dn  = 2'b01;
`ifdef LZ_BLANK_EN
            e.seg = (m_s2 == 4'h0) ? 7'h7F : dec_tab[m_s2];
`else
            e.seg = dec_tab[m_s2];
`endif
            e.dp  = ~m_ovf;
        end
        m_k++;
        q.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: every cycle with a pending expectation is checked 1 time unit
    // after the rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                chk("seg",     bus.Seg,            e.seg);
                chk("dp",      {6'd0, bus.Dp},     {6'd0, e.dp});
                chk("digit_n", {5'd0, bus.Digit_N}, {5'd0, e.dn});
                chk("ovf",     {6'd0, bus.Ovf},    {6'd0, e.ovf});
            end
        end
    end

    initial begin
        Reset_N      = 1'b0;
        bus.Qin1     = 4'h0;
        bus.Qin2     = 4'h0;
        bus.Carry_in = 2'b00;
        bus.Ovf_Clr  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_seg",     bus.Seg,             7'h7F);
        chk("rst_dp",      {6'd0, bus.Dp},      7'd1);
        chk("rst_digit_n", {5'd0, bus.Digit_N}, 7'd3);
        chk("rst_ovf",     {6'd0, bus.Ovf},     7'd0);
        Reset_N = 1'b1;

        // Basic frame, then a mid-frame change of Qin1 that must wait a frame.
        repeat (16) cyc(4'h4, 4'h3, 2'b00, 1'b0);
        cyc(4'h4, 4'h3, 2'b00, 1'b0);
        repeat (15) cyc(4'h9, 4'h3, 2'b00, 1'b0);

        // Overflow set, clear, and simultaneous set+clear.
        cyc(4'h9, 4'h3, 2'b10, 1'b0);
        repeat (10) cyc(4'h9, 4'h3, 2'b00, 1'b0);
        cyc(4'h9, 4'h3, 2'b00, 1'b1);
        repeat (3) cyc(4'h9, 4'h3, 2'b00, 1'b0);
        cyc(4'h9, 4'h3, 2'b10, 1'b1);
        repeat (8) cyc(4'h9, 4'h3, 2'b00, 1'b0);

        // Low carry with F, and a zero high digit.
        repeat (16) cyc(4'hF, 4'h0, 2'b01, 1'b0);

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            cyc(4'($urandom), 4'($urandom),
                {1'($urandom_range(0, 19) == 0), 1'($urandom)},
                1'($urandom_range(0, 9) == 0));
        end

        // Move to the middle of the high-digit slot with Ovf forced high.
        for (int i = 0; i < 4 * SD && (m_k % (2 * SD)) != SD + 1; i++)
            cyc(4'h5, 4'h6, 2'b10, 1'b0);
        repeat (2 * SD) cyc(4'h5, 4'h6, 2'b10, 1'b0);
        for (int i = 0; i < 4 * SD && (m_k % (2 * SD)) != SD + 1; i++)
            cyc(4'h5, 4'h6, 2'b00, 1'b0);
        chk("pre_rst_digit_n", {5'd0, bus.Digit_N}, 7'd1);
        chk("pre_rst_ovf",     {6'd0, bus.Ovf},     7'd1);
        #2;
        Reset_N = 1'b0;
        #1;
        chk("async_rst_seg",     bus.Seg,             7'h7F);
        chk("async_rst_dp",      {6'd0, bus.Dp},      7'd1);
        chk("async_rst_digit_n", {5'd0, bus.Digit_N}, 7'd3);
        chk("async_rst_ovf",     {6'd0, bus.Ovf},     7'd0);
        m_k   = 0;
        m_ovf = 1'b0;
        m_s1  = '0;
        m_s2  = '0;
        m_sc  = 1'b0;
        @(negedge clk);
        Reset_N = 1'b1;
        for (int i = 0; i < 40; i++) begin
            cyc(4'($urandom), 4'($urandom),
                {1'($urandom_range(0, 15) == 0), 1'($urandom)}, 1'b0);
        end

        @(negedge clk);
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
